// File: rtl/pc_unit_if.sv
// pc_unit_if: control and status bundle between decode/hazard logic and the PC unit.
//   master : decode side, drives PCWrite/op/branch_taken/offset/target, observes PC state
//   slave  : pc_unit, consumes control, drives PCout/ras_count/ras_overflow/ras_underflow
interface pc_unit_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned RAS_DEPTH  = 4
);
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

    logic                  PCWrite;
    logic [2:0]            op;
    logic                  branch_taken;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] PCout;
    logic [CntW-1:0]       ras_count;
    logic                  ras_overflow;
    logic                  ras_underflow;

    modport master (
        output PCWrite, op, branch_taken, offset, target,
        input  PCout, ras_count, ras_overflow, ras_underflow
    );

    modport slave (
        input  PCWrite, op, branch_taken, offset, target,
        output PCout, ras_count, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC selection and a circular return-address stack.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : pc_unit_if.slave
//     PCWrite      - 1 = advance state, 0 = hold everything
//     op           - 0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET, 5 TRAP, 6/7 as SEQ
//     branch_taken - qualifies BRANCH
//     offset       - signed branch displacement
//     target       - JUMP/CALL destination
//     PCout        - registered PC
//     ras_count    - registered number of valid RAS entries
//     ras_overflow / ras_underflow - sticky error flags
module pc_unit #(
    parameter int unsigned          ADDR_WIDTH   = 16,
    parameter int unsigned          PC_INC       = 1,
    parameter int unsigned          RAS_DEPTH    = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = ADDR_WIDTH'(16'h0010)
) (
    input logic       clk,
    input logic       reset,
    pc_unit_if.slave  bus
);
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);

    localparam logic [2:0] OpBranch = 3'd1;
    localparam logic [2:0] OpJump   = 3'd2;
    localparam logic [2:0] OpCall   = 3'd3;
    localparam logic [2:0] OpRet    = 3'd4;
    localparam logic [2:0] OpTrap   = 3'd5;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [PtrW-1:0]       top_q, top_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];

    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [PtrW-1:0]       top_next, top_prev;
    logic                  push;

    assign pc_inc   = pc_q + ADDR_WIDTH'(PC_INC);
    // Pointer wraps explicitly so non-power-of-two depths work too.
    assign top_next = (top_q == PtrW'(RAS_DEPTH - 1)) ? '0 : top_q + PtrW'(1);
    assign top_prev = (top_q == '0) ? PtrW'(RAS_DEPTH - 1) : top_q - PtrW'(1);

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        top_d = top_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        if (bus.PCWrite) begin
            case (bus.op)
                OpBranch: pc_d = bus.branch_taken ? pc_q + bus.offset : pc_inc;
                OpJump:   pc_d = bus.target;
                OpCall: begin
                    // When full, top_next lands on the oldest entry, which is overwritten.
                    push  = 1'b1;
                    top_d = top_next;
                    pc_d  = bus.target;
                    if (cnt_q == CntW'(RAS_DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                OpRet: begin
                    if (cnt_q != '0) begin
                        pc_d  = ras_q[top_q];
                        top_d = top_prev;
                        cnt_d = cnt_q - CntW'(1);
                    end else begin
                        pc_d  = pc_inc;
                        unf_d = 1'b1;
                    end
                end
                OpTrap:   pc_d = TRAP_VECTOR;
                default:  pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_VECTOR;
            cnt_q <= '0;
            top_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            top_q <= top_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry contents need no reset; ras_count alone defines validity.
    always_ff @(posedge clk) begin
        if (push && reset) begin
            ras_q[top_next] <= pc_inc;
        end
    end

    assign bus.PCout         = pc_q;
    assign bus.ras_count     = cnt_q;
    assign bus.ras_overflow  = ovf_q;
    assign bus.ras_underflow = unf_q;
endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic reset;

    pc_unit_if #(.ADDR_WIDTH(AW), .RAS_DEPTH(DEPTH)) bus ();

    pc_unit #(
        .ADDR_WIDTH  (AW),
        .PC_INC      (1),
        .RAS_DEPTH   (DEPTH),
        .RESET_VECTOR(16'h0000),
        .TRAP_VECTOR (16'h0010)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: PC value plus a bounded LIFO list of return addresses.
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_ras[$];
    logic          m_ovf;
    logic          m_unf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".pc"},  32'(bus.PCout),         32'(m_pc));
        check_eq({tag, ".cnt"}, 32'(bus.ras_count),     32'(m_ras.size()));
        check_eq({tag, ".ovf"}, 32'(bus.ras_overflow),  32'(m_ovf));
        check_eq({tag, ".unf"}, 32'(bus.ras_underflow), 32'(m_unf));
    endtask

    task automatic model_reset();
        m_pc = 16'h0000;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic pcw, input logic [2:0] op, input logic tk,
                              input logic [AW-1:0] off, input logic [AW-1:0] tgt);
        if (pcw) begin
            case (op)
                3'd1: m_pc = tk ? m_pc + off : m_pc + 16'd1;
                3'd2: m_pc = tgt;
                3'd3: begin
                    m_ras.push_back(m_pc + 16'd1);
                    if (m_ras.size() > DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_pc = tgt;
                end
                3'd4: begin
                    if (m_ras.size() > 0) begin
                        m_pc = m_ras.pop_back();
                    end else begin
                        m_pc  = m_pc + 16'd1;
                        m_unf = 1'b1;
                    end
                end
                3'd5: m_pc = 16'h0010;
                default: m_pc = m_pc + 16'd1;
            endcase
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs sampled at the same point.
    task automatic step(input string tag, input logic pcw, input logic [2:0] op, input logic tk,
                        input logic [AW-1:0] off, input logic [AW-1:0] tgt);
        bus.PCWrite      = pcw;
        bus.op           = op;
        bus.branch_taken = tk;
        bus.offset       = off;
        bus.target       = tgt;
        model_step(pcw, op, tk, off, tgt);
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    // Assert reset between edges and check it acts before any clock edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_state(tag);
        @(posedge clk);
        #1;
        check_state({tag, ".held"});
        reset = 1'b1;
    endtask

    initial begin
        reset            = 1'b0;
        bus.PCWrite      = 1'b1;
        bus.op           = 3'd0;
        bus.branch_taken = 1'b0;
        bus.offset       = '0;
        bus.target       = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        reset = 1'b1;

        // Sequential after reset
        step("seq1", 1, 0, 0, 0, 0);
        step("seq2", 1, 0, 0, 0, 0);
        step("seq3", 1, 0, 0, 0, 0);
        check_eq("seq3.abs", 32'(bus.PCout), 32'h3);
        async_reset("areset");
        check_eq("areset.abs", 32'(bus.PCout), 32'h0);

        // Stall, then branches
        step("jmp20", 1, 2, 0, 0, 16'h0020);
        step("stall1", 0, 2, 0, 0, 16'h1234);
        step("stall2", 0, 2, 0, 0, 16'h1234);
        check_eq("stall.abs", 32'(bus.PCout), 32'h20);
        step("br_back", 1, 1, 1, 16'hFFFC, 0);
        check_eq("br_back.abs", 32'(bus.PCout), 32'h1C);
        step("br_not", 1, 1, 0, 16'hFFFC, 0);
        check_eq("br_not.abs", 32'(bus.PCout), 32'h1D);

        // Wrap-around
        step("jmpffff", 1, 2, 0, 0, 16'hFFFF);
        step("seqwrap", 1, 0, 0, 0, 0);
        check_eq("seqwrap.abs", 32'(bus.PCout), 32'h0);
        step("jmpfffe", 1, 2, 0, 0, 16'hFFFE);
        step("brwrap", 1, 1, 1, 16'h0005, 0);
        check_eq("brwrap.abs", 32'(bus.PCout), 32'h3);

        // Nested call/return
        step("jmp100", 1, 2, 0, 0, 16'h0100);
        step("call200", 1, 3, 0, 0, 16'h0200);
        step("call300", 1, 3, 0, 0, 16'h0300);
        step("ret1", 1, 4, 1, 0, 0);
        check_eq("ret1.abs", 32'(bus.PCout), 32'h201);
        step("ret2", 1, 4, 0, 0, 0);
        check_eq("ret2.abs", 32'(bus.PCout), 32'h101);

        // Overflow then underflow
        step("jmp10", 1, 2, 0, 0, 16'h0010);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("ocall%0d", i), 1, 3, 0, 0, 16'((i + 2) * 16'h10));
        end
        check_eq("ovf.cnt.abs", 32'(bus.ras_count), 32'd4);
        check_eq("ovf.flag.abs", 32'(bus.ras_overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("oret%0d", i), 1, 4, 0, 0, 0);
            check_eq($sformatf("oret%0d.abs", i), 32'(bus.PCout), 32'(16'h51 - 16'(i * 16)));
        end
        step("uret", 1, 4, 0, 0, 0);
        check_eq("uret.abs", 32'(bus.PCout), 32'h22);
        check_eq("unf.flag.abs", 32'(bus.ras_underflow), 32'd1);

        // Trap and reserved op
        async_reset("areset2");
        step("jmp1", 1, 2, 0, 0, 16'h0001);
        step("tcall1", 1, 3, 0, 0, 16'h0002);
        step("tcall2", 1, 3, 0, 0, 16'h0040);
        step("trap", 1, 5, 1, 0, 16'h7777);
        check_eq("trap.abs", 32'(bus.PCout), 32'h10);
        check_eq("trap.cnt.abs", 32'(bus.ras_count), 32'd2);
        step("op7", 1, 7, 1, 16'h0100, 16'h7777);
        check_eq("op7.abs", 32'(bus.PCout), 32'h11);

        // Randomized traffic, biased toward CALL/RET to exercise the stack edges
        for (int i = 0; i < 600; i++) begin
            logic [2:0] rop;
            logic       rpcw;
            if ($urandom_range(0, 79) == 0) begin
                async_reset($sformatf("rrst%0d", i));
            end
            rop  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7))
                                               : 3'($urandom_range(3, 4));
            rpcw = ($urandom_range(0, 5) != 0);
            step($sformatf("rnd%0d", i), rpcw, rop, 1'($urandom), 16'($urandom),
                 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the single-register PC.
- Holds the PC and computes next-PC internally: sequential, conditional relative branch, absolute jump, call/return via an internal return-address stack (RAS), and trap vectoring.
- Sits at the head of the fetch stage. PCout drives instruction-memory address. Control comes from decode/hazard logic through op, branch_taken and PCWrite.

Parameters:
- ADDR_WIDTH, 16, width of PC, offset, target and RAS entries.
- PC_INC, 1, sequential increment (address units per instruction).
- RAS_DEPTH, 4, number of return-address stack entries (>=2).
- RESET_VECTOR, 0, PC value loaded on reset.
- TRAP_VECTOR, 16'h0010, PC value loaded on a trap (sized to ADDR_WIDTH).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- PCWrite  input  1  1 = update PC/RAS this cycle; 0 = stall, all state held
- op  input  3  next-PC operation: 0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET, 5 TRAP, 6/7 reserved
- branch_taken  input  1  qualifies BRANCH only
- offset  input  ADDR_WIDTH  two's-complement branch displacement, added to current PC
- target  input  ADDR_WIDTH  absolute destination for JUMP/CALL
- PCout  output  ADDR_WIDTH  current PC, registered
- ras_count  output  clog2(RAS_DEPTH+1)  valid RAS entries, registered
- ras_overflow  output  1  sticky: a CALL was issued with RAS full
- ras_underflow  output  1  sticky: a RET was issued with RAS empty

Behaviour:
- Reset (reset=0, asynchronous, regardless of clk):
  - PCout=RESET_VECTOR, ras_count=0, ras_overflow=0, ras_underflow=0.
  - RAS entry contents are don't-care.
  - Reset mid-operation discards any pending update. The first edge after release acts normally.
- PCWrite=0: PCout, RAS contents, ras_count and flags all hold. op and the other inputs are ignored.
- PCWrite=1, one-cycle latency: the new PC is visible on PCout after the rising edge.
  - SEQ: PCout <= PCout+PC_INC.
  - BRANCH: if branch_taken, PCout <= PCout+offset; else PCout+PC_INC.
  - JUMP: PCout <= target.
  - CALL: push PCout+PC_INC onto the RAS, then PCout <= target.
  - RET: pop the top of the RAS into PCout.
  - TRAP: PCout <= TRAP_VECTOR; RAS untouched.
  - 6/7: behave as SEQ.
- Arithmetic: all sums are modulo 2^ADDR_WIDTH; wrap-around is silent, with no flag. offset is sign-interpreted, so all-ones means -1.
- RAS organisation: circular buffer with a top pointer.
  - CALL when ras_count<RAS_DEPTH: write the entry, increment ras_count.
  - CALL when full: overwrite the oldest entry (the new entry becomes top), ras_count stays RAS_DEPTH, ras_overflow<=1.
  - RET when ras_count>0: PCout <= top entry, decrement ras_count.
  - RET when empty: PCout <= PCout+PC_INC (fall through), ras_count stays 0, ras_underflow<=1.
  - After an overflow, RAS_DEPTH successive RETs return the newest RAS_DEPTH addresses in LIFO order. Older addresses are lost.
- Sticky flags clear only on reset.
- Only one op per cycle, so push and pop are never simultaneous.
- branch_taken is ignored for every op except BRANCH.
- No combinational path from inputs to any output.

Test Plan:
- Reset/SEQ: hold reset=0 → PCout=0. Release, PCWrite=1, op=SEQ for 3 edges → PCout 1,2,3. Assert reset=0 between edges → PCout=0 immediately, without waiting for a clock edge.
- Stall/branch: PCout=0x0020, PCWrite=0, op=JUMP, target=0x1234 for 2 edges → PCout stays 0x0020. Then PCWrite=1, BRANCH, taken=1, offset=0xFFFC → 0x001C. Then taken=0 → 0x001D.
- Wrap: PCout=0xFFFF, SEQ → 0x0000. Then BRANCH, taken, offset=0x0005 from 0xFFFE → 0x0003.
- Call/return nesting, from PC=0x0100:
  - CALL target=0x0200 → PCout=0x0200, ras_count=1.
  - CALL target=0x0300 → PCout=0x0300, ras_count=2.
  - RET → 0x0201, ras_count=1.
  - RET → 0x0101, ras_count=0. No flags set.
- RAS overflow (RAS_DEPTH=4): 5 CALLs from PCs 0x10,0x20,0x30,0x40,0x50 → ras_count=4, ras_overflow=1. Then 4 RETs → 0x51,0x41,0x31,0x21. A 5th RET falls through to 0x22 and sets ras_underflow=1.
- Trap/reserved: PCout=0x0040, ras_count=2, op=TRAP → PCout=0x0010, ras_count=2. Then op=7 → 0x0011. Flags unchanged.
